// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU for the MIPS datapath.
// Logic/arithmetic ops complete in one cycle; unsigned DIV/MOD run on a
// restoring divider that resolves one quotient bit per clock. A start/done
// handshake fronts the block and busy stalls the control FSM.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alu_ctr,
  input  logic [WIDTH-1:0] alu_src1,
  input  logic [WIDTH-1:0] alu_src2,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_bit,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH:0]   rem_reg, rem_next;      // partial remainder, one guard bit
  logic [WIDTH-1:0] quo_reg, quo_next;      // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] divisor_reg, divisor_next;
  logic             is_mod_reg, is_mod_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             zero_reg, zero_next;
  logic             dbz_reg, dbz_next;

  logic [WIDTH-1:0] op_result;
  logic [WIDTH+1:0] trial;
  logic             trial_neg;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             is_div_op;

  assign alu_result  = result_reg;
  assign zero_bit    = zero_reg;
  assign div_by_zero = dbz_reg;
  assign done        = (state_reg == DONE);
  assign busy        = (state_reg != IDLE);

  // 101 (DIV) and 111 (MOD) are the only iterative opcodes; bit 1 picks MOD.
  assign is_div_op = alu_ctr[2] & alu_ctr[0];

  // Single-cycle datapath, evaluated on the live operands.
  always_comb begin
    op_result = '0;
    case (alu_ctr)
      3'b000:  op_result = alu_src1 & alu_src2;
      3'b001:  op_result = alu_src1 | alu_src2;
      3'b010:  op_result = alu_src1 + alu_src2;
      3'b011:  op_result = alu_src1 ^ alu_src2;
      3'b100:  op_result = ~(alu_src1 | alu_src2);
      3'b110:  op_result = alu_src1 - alu_src2;
      default: op_result = '0;
    endcase
  end

  // One restoring step: shift {rem, quo} left, trial-subtract the divisor,
  // keep the difference only when it did not go negative.
  always_comb begin
    trial     = {rem_reg, quo_reg[WIDTH-1]} - {2'b00, divisor_reg};
    trial_neg = trial[WIDTH+1];
    step_rem  = trial_neg ? {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]} : trial[WIDTH:0];
    step_quo  = {quo_reg[WIDTH-2:0], ~trial_neg};
  end

  // Next-state and datapath-load logic; every register holds by default.
  always_comb begin
    state_next   = state_reg;
    rem_next     = rem_reg;
    quo_next     = quo_reg;
    divisor_next = divisor_reg;
    is_mod_next  = is_mod_reg;
    count_next   = count_reg;
    result_next  = result_reg;
    dbz_next     = dbz_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (is_div_op) begin
            if (alu_src2 == '0) begin
              // Divide by zero: no iteration, DIV saturates, MOD returns A.
              result_next = alu_ctr[1] ? alu_src1 : '1;
              dbz_next    = 1'b1;
              state_next  = DONE;
            end else begin
              divisor_next = alu_src2;
              is_mod_next  = alu_ctr[1];
              rem_next     = '0;
              quo_next     = alu_src1;
              count_next   = COUNT_INIT;
              state_next   = DIVIDE;
            end
          end else begin
            result_next = op_result;
            dbz_next    = 1'b0;
            state_next  = DONE;
          end
        end
      end
      DIVIDE: begin
        rem_next   = step_rem;
        quo_next   = step_quo;
        count_next = count_reg - COUNT_ONE;
        if (count_reg == COUNT_ONE) begin
          result_next = is_mod_reg ? step_rem[WIDTH-1:0] : step_quo;
          dbz_next    = 1'b0;
          state_next  = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // result_reg and zero_reg always move together, so this tracks the result.
    zero_next = ~|result_next;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      rem_reg     <= '0;
      quo_reg     <= '0;
      divisor_reg <= '0;
      is_mod_reg  <= 1'b0;
      count_reg   <= '0;
      result_reg  <= '0;
      zero_reg    <= 1'b1;
      dbz_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rem_reg     <= rem_next;
      quo_reg     <= quo_next;
      divisor_reg <= divisor_next;
      is_mod_reg  <= is_mod_next;
      count_reg   <= count_next;
      result_reg  <= result_next;
      zero_reg    <= zero_next;
      dbz_reg     <= dbz_next;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu: a WIDTH=32 and a WIDTH=8 instance driven
// from one linear initial block with hand-computed expected values.
module tb_seq_alu;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, start8;
  logic [2:0]  ctr32, ctr8;
  logic [31:0] a32, b32, res32;
  logic [7:0]  a8, b8, res8;
  logic        zero32, done32, busy32, dbz32;
  logic        zero8, done8, busy8, dbz8;

  int checks = 0;
  int errors = 0;
  int lat, busy_n, done_n;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .alu_ctr(ctr32),
    .alu_src1(a32), .alu_src2(b32), .alu_result(res32), .zero_bit(zero32),
    .done(done32), .busy(busy32), .div_by_zero(dbz32)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .alu_ctr(ctr8),
    .alu_src1(a8), .alu_src2(b8), .alu_result(res8), .zero_bit(zero8),
    .done(done8), .busy(busy8), .div_by_zero(dbz8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the 32-bit DUT idle. Returns in the
  // cycle where done is seen (or after the cycle budget expires).
  task automatic run32(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                       input bit scramble,
                       output int l, output int bn, output int dn);
    start32 = 1'b1; ctr32 = c; a32 = a; b32 = b;
    @(posedge clk); #1;
    if (!scramble) start32 = 1'b0;
    l = 1; bn = 0; dn = 0;
    forever begin
      if (busy32) bn++;
      if (done32) begin dn++; break; end
      if (l >= 100) break;
      if (scramble) begin
        a32 = $urandom; b32 = $urandom; ctr32 = 3'($urandom_range(0, 7));
      end
      @(posedge clk); #1;
      l++;
    end
    $display("txn w32 op=%b a=%h b=%h -> res=%h zero=%b dbz=%b latency=%0d",
             c, a, b, res32, zero32, dbz32, l);
  endtask

  task automatic run8(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b,
                      output int l);
    start8 = 1'b1; ctr8 = c; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    l = 1;
    while (!done8 && l < 100) begin
      @(posedge clk); #1;
      l++;
    end
    $display("txn w8 op=%b a=%h b=%h -> res=%h zero=%b latency=%0d",
             c, a, b, res8, zero8, l);
  endtask

  initial begin
    reset = 1'b1;
    start32 = 1'b0; ctr32 = '0; a32 = '0; b32 = '0;
    start8 = 1'b0;  ctr8 = '0;  a8 = '0;  b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", 64'(res32), 64'h0);
    chk("rst_zero", 64'(zero32), 64'h1);
    chk("rst_done", 64'(done32), 64'h0);
    chk("rst_busy", 64'(busy32), 64'h0);
    chk("rst_dbz", 64'(dbz32), 64'h0);
    reset = 1'b0;

    // ADD wraps to zero
    run32(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, lat, busy_n, done_n);
    chk("add_wrap_res", 64'(res32), 64'h0);
    chk("add_wrap_zero", 64'(zero32), 64'h1);
    chk("add_wrap_lat", 64'(lat), 64'd1);
    chk("add_wrap_busy", 64'(busy_n), 64'd1);
    @(posedge clk); #1;
    chk("add_done_fall", 64'(done32), 64'h0);

    // SUB 9 - 4
    run32(OP_SUB, 32'd9, 32'd4, 1'b0, lat, busy_n, done_n);
    chk("sub_res", 64'(res32), 64'd5);
    chk("sub_zero", 64'(zero32), 64'h0);
    chk("sub_lat", 64'(lat), 64'd1);
    @(posedge clk); #1;

    // Remainder of 100 by 7
    run32(OP_MOD, 32'd100, 32'd7, 1'b0, lat, busy_n, done_n);
    chk("mod_res", 64'(res32), 64'd2);
    chk("mod_lat", 64'(lat), 64'd33);
    chk("mod_busy", 64'(busy_n), 64'd33);
    chk("mod_dbz", 64'(dbz32), 64'h0);
    @(posedge clk); #1;
    chk("mod_done_fall", 64'(done32), 64'h0);
    chk("mod_busy_fall", 64'(busy32), 64'h0);

    // DIV 100, 7
    run32(OP_DIV, 32'd100, 32'd7, 1'b0, lat, busy_n, done_n);
    chk("div_res", 64'(res32), 64'd14);
    chk("div_lat", 64'(lat), 64'd33);
    chk("div_busy", 64'(busy_n), 64'd33);
    chk("div_dbz", 64'(dbz32), 64'h0);
    @(posedge clk); #1;

    // Divide by zero
    run32(OP_DIV, 32'd5, 32'd0, 1'b0, lat, busy_n, done_n);
    chk("div0_res", 64'(res32), 64'hFFFF_FFFF);
    chk("div0_dbz", 64'(dbz32), 64'h1);
    chk("div0_lat", 64'(lat), 64'd1);
    @(posedge clk); #1;
    run32(OP_MOD, 32'd5, 32'd0, 1'b0, lat, busy_n, done_n);
    chk("mod0_res", 64'(res32), 64'd5);
    chk("mod0_dbz", 64'(dbz32), 64'h1);
    chk("mod0_lat", 64'(lat), 64'd1);
    @(posedge clk); #1;
    run32(OP_AND, 32'hF0, 32'h0F, 1'b0, lat, busy_n, done_n);
    chk("and_res", 64'(res32), 64'h0);
    chk("and_zero", 64'(zero32), 64'h1);
    chk("and_dbz", 64'(dbz32), 64'h0);
    @(posedge clk); #1;

    // Remainder of 1000 by 3 with start held and operands churning during DIVIDE
    run32(OP_MOD, 32'd1000, 32'd3, 1'b1, lat, busy_n, done_n);
    chk("hold_res", 64'(res32), 64'd1);
    chk("hold_lat", 64'(lat), 64'd33);
    chk("hold_done_cnt", 64'(done_n), 64'd1);
    ctr32 = OP_ADD; a32 = 32'd2; b32 = 32'd3;
    @(posedge clk); #1;
    chk("hold_idle_busy", 64'(busy32), 64'h0);
    chk("hold_idle_done", 64'(done32), 64'h0);
    chk("hold_idle_res", 64'(res32), 64'd1);
    @(posedge clk); #1;
    start32 = 1'b0;
    chk("hold_next_done", 64'(done32), 64'h1);
    chk("hold_next_res", 64'(res32), 64'd5);
    $display("txn w32 held-start follow-on ADD 2+3 -> res=%h", res32);
    @(posedge clk); #1;

    // Reset 10 cycles into a DIV; a start in the reset cycle is dropped
    start32 = 1'b1; ctr32 = OP_DIV; a32 = 32'hFFFF_FFFF; b32 = 32'h10;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort_pre_busy", 64'(busy32), 64'h1);
    reset = 1'b1;
    start32 = 1'b1; ctr32 = OP_ADD; a32 = 32'd3; b32 = 32'd4;
    @(posedge clk); #1;
    reset = 1'b0; start32 = 1'b0;
    chk("abort_busy", 64'(busy32), 64'h0);
    chk("abort_res", 64'(res32), 64'h0);
    chk("abort_zero", 64'(zero32), 64'h1);
    chk("abort_done", 64'(done32), 64'h0);
    done_n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) done_n++;
    end
    chk("abort_no_done", 64'(done_n), 64'd0);
    chk("abort_res_hold", 64'(res32), 64'h0);
    $display("txn w32 reset abort -> busy=%b res=%h", busy32, res32);
    run32(OP_DIV, 32'hFFFF_FFFF, 32'h10, 1'b0, lat, busy_n, done_n);
    chk("fresh_div_res", 64'(res32), 64'h0FFF_FFFF);
    chk("fresh_div_lat", 64'(lat), 64'd33);
    @(posedge clk); #1;

    // WIDTH=8 instance
    run8(OP_MOD, 8'd200, 8'd13, lat);
    chk("w8_mod_res", 64'(res8), 64'd5);
    chk("w8_mod_lat", 64'(lat), 64'd9);
    @(posedge clk); #1;
    chk("w8_done_fall", 64'(done8), 64'h0);
    run8(OP_DIV, 8'd200, 8'd13, lat);
    chk("w8_div_res", 64'(res8), 64'd15);
    chk("w8_div_lat", 64'(lat), 64'd9);
    chk("w8_div_dbz", 64'(dbz8), 64'h0);
    @(posedge clk); #1;
    run8(OP_ADD, 8'hFF, 8'h02, lat);
    chk("w8_add_res", 64'(res8), 64'h01);
    chk("w8_add_zero", 64'(zero8), 64'h0);
    chk("w8_add_lat", 64'(lat), 64'd1);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU for the MIPS datapath. It executes single-cycle logic and arithmetic ops, plus iterative unsigned DIV and MOD, behind a start/done handshake. Quotient and remainder come from a restoring divider that resolves one bit per clock. `zero_bit` is a true result-is-zero flag, separate from completion. The block sits at the datapath's ALU slot; the control FSM stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand and result width; legal range 4–64.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: op request; sampled only in IDLE.
- `alu_ctr` in 3: opcode; latched when `start` is accepted.
- `alu_src1` in WIDTH: operand A (dividend).
- `alu_src2` in WIDTH: operand B (divisor).
- `alu_result` out WIDTH: registered result; held until the next completion.
- `zero_bit` out 1: registered; 1 when `alu_result == 0`.
- `done` out 1: one-cycle completion pulse.
- `busy` out 1: 1 whenever state is not IDLE.
- `div_by_zero` out 1: registered; set on completion of DIV/MOD with B = 0, cleared on completion of any other op.

## Operation
- Opcodes:
  - 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 110 SUB: single-cycle.
  - 101 DIV: quotient, iterative.
  - 111 MOD: remainder, iterative.
- ADD and SUB wrap modulo 2^WIDTH; there is no carry or overflow output.
- FSM states are IDLE, DIVIDE and DONE.
- IDLE with `start` = 1 and a single-cycle op:
  - compute from live operands;
  - register `alu_result` and `zero_bit`;
  - go to DONE.
- IDLE with `start` = 1 and DIV/MOD, B ≠ 0:
  - latch A, B and `alu_ctr`;
  - clear the (WIDTH+1)-bit partial remainder;
  - load the quotient register with A;
  - set the step counter to WIDTH;
  - go to DIVIDE.
- IDLE with `start` = 1 and DIV/MOD, B = 0:
  - no iteration;
  - DIV result is all ones; MOD result is A;
  - `div_by_zero` = 1;
  - go to DONE.
- DIVIDE, one restoring step per cycle:
  - shift {remainder, quotient} left by 1;
  - trial-subtract B from the remainder;
  - if non-negative, keep the difference and set quotient LSB to 1, else restore and set it to 0;
  - decrement the counter.
  - On the step where the counter reaches 0: register the quotient (DIV) or remainder (MOD) into `alu_result`, update `zero_bit`, go to DONE.
- DONE: `done` = 1 for exactly this cycle, then return to IDLE unconditionally.
- `start` is ignored in DIVIDE and DONE.
- Operand or opcode changes during DIVIDE have no effect.
- Reset values:
  - `alu_result` = 0, `zero_bit` = 1;
  - `done` = 0, `busy` = 0, `div_by_zero` = 0;
  - state IDLE, counter 0.
- Reset mid-operation aborts immediately: IDLE on the next cycle, no `done` pulse, outputs at reset values.
- `start` asserted in the same cycle as `reset`: `reset` wins and the request is dropped.

## Timing
- Let E0 be the rising edge that samples an accepted `start`.
- Single-cycle op, or DIV/MOD with B = 0:
  - `alu_result`, `zero_bit` and `div_by_zero` update at E0;
  - `done` and `busy` are high for the single cycle after E0;
  - the next `start` can be accepted at E0+2.
- DIV/MOD with B ≠ 0:
  - `busy` is high from E0 through the cycle after E0+WIDTH;
  - steps execute at E0+1 … E0+WIDTH;
  - the result updates at E0+WIDTH;
  - `done` is high for the single cycle after E0+WIDTH;
  - total latency is WIDTH+1 cycles start-to-done.
- `alu_result`, `zero_bit` and `div_by_zero` are stable everywhere outside the completion edge.
- `done` is never high two consecutive cycles.

## Test plan
- WIDTH=32, ADD 0xFFFFFFFF + 0x1 → `alu_result` 0, `zero_bit` 1, `done` exactly one cycle after the start edge; then SUB 9 − 4 → 5, `zero_bit` 0.
- WIDTH=32, MOD 100, 7 → 2; DIV 100, 7 → 14; `busy` high 33 cycles; `done` a single pulse 33 cycles after start; `div_by_zero` 0.
- WIDTH=32, DIV 5, 0 → 0xFFFFFFFF and MOD 5, 0 → 5, each with `div_by_zero` 1 and `done` one cycle after start; a following AND 0xF0, 0x0F → 0, `zero_bit` 1, `div_by_zero` 0.
- WIDTH=32:
  - MOD 1000, 3 started, then `start` held high with changing operands during DIVIDE → result 1, no extra `done` while busy;
  - a new start accepted only after `done` falls.
- WIDTH=32, DIV 0xFFFFFFFF, 0x10, `reset` asserted 10 cycles after start:
  - next cycle `busy` 0, `alu_result` 0, `zero_bit` 1, no `done` ever;
  - a fresh DIV 0xFFFFFFFF, 0x10 → 0x0FFFFFFF.
- WIDTH=8: MOD 200, 13 → 5 and DIV 200, 13 → 15, each with `done` 9 cycles after start; ADD 0xFF + 0x02 → 0x01.
